// File: rtl/dc_motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dc_motor_pkg
//  Brief    : Default constants and helpers shared by the dc_motor PWM block
//  Revision : 1.0  initial release
// ============================================================================
package dc_motor_pkg;

    localparam int CNT_W      = 8;
    localparam int DUTY_STEP  = 32;
    localparam int REPEAT_CYC = 4096;
    localparam int PWM_MAX    = 1 << CNT_W;

    function automatic int pwm_max(input int cnt_w);
        return 1 << cnt_w;
    endfunction

    // A repeat period of 1 still needs a 1-bit timer
    function automatic int timer_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_motor_btn.sv
`default_nettype none
// ============================================================================
//  Module   : dc_motor_btn
//  Brief    : Button conditioner: 2-flop sync, rising-edge event, auto-repeat
//  Revision : 1.0  initial release
// ============================================================================
module dc_motor_btn
    import dc_motor_pkg::*;
#(
    parameter int REPEAT_CYC = dc_motor_pkg::REPEAT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic evt
);

    localparam int               C_TW   = timer_width(REPEAT_CYC);
    localparam logic [C_TW-1:0]  C_LAST = C_TW'(REPEAT_CYC - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q,  prev_d;
    logic [C_TW-1:0] timer_q, timer_d;

    logic w_edge;
    logic w_held;
    logic w_rep;

    always_comb begin
        sync1_d = level;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        w_edge  = sync2_q & ~prev_q;
        w_held  = sync2_q & prev_q;
        // Timer starts the cycle after the edge, so a repeat lands REPEAT_CYC clocks after it
        w_rep   = w_held && (timer_q == C_LAST);
        timer_d = '0;
        if (w_held && !w_rep) begin
            timer_d = timer_q + C_TW'(1);
        end
        evt = w_edge | w_rep;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            timer_q <= timer_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dc_motor.sv
`default_nettype none
// ============================================================================
//  Module   : dc_motor
//  Brief    : PWM speed controller for an H-bridge with inc/dec duty buttons
//  Revision : 1.0  initial release
// ============================================================================
module dc_motor
    import dc_motor_pkg::*;
#(
    parameter int CNT_W      = dc_motor_pkg::CNT_W,
    parameter int DUTY_STEP  = dc_motor_pkg::DUTY_STEP,
    parameter int REPEAT_CYC = dc_motor_pkg::REPEAT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic pwm_out,
    output logic nsleep
);

    localparam int                C_FULL   = pwm_max(CNT_W);
    localparam logic [CNT_W+1:0]  C_FULL_W = (CNT_W+2)'(C_FULL);
    localparam logic [CNT_W+1:0]  C_STEP_W = (CNT_W+2)'(DUTY_STEP);
    localparam logic [CNT_W:0]    C_STEP_N = (CNT_W+1)'(DUTY_STEP);

    logic w_inc_evt;
    logic w_dec_evt;

    dc_motor_btn #(.REPEAT_CYC(REPEAT_CYC)) u_btn_inc (
        .clk   (clk),
        .rst   (rst),
        .level (inc),
        .evt   (w_inc_evt)
    );

    dc_motor_btn #(.REPEAT_CYC(REPEAT_CYC)) u_btn_dec (
        .clk   (clk),
        .rst   (rst),
        .level (dec),
        .evt   (w_dec_evt)
    );

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W:0]   duty_req_q, duty_req_d;
    logic [CNT_W:0]   duty_act_q, duty_act_d;
    logic             pwm_q,      pwm_d;
    logic             nsleep_q,   nsleep_d;

    logic [CNT_W+1:0] w_sum;

    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        w_sum      = {1'b0, duty_req_q} + C_STEP_W;
        duty_req_d = duty_req_q;
        if (w_inc_evt && !w_dec_evt) begin
            duty_req_d = (w_sum > C_FULL_W) ? C_FULL_W[CNT_W:0] : w_sum[CNT_W:0];
        end else if (w_dec_evt && !w_inc_evt) begin
            duty_req_d = (duty_req_q > C_STEP_N) ? (duty_req_q - C_STEP_N) : '0;
        end
        // Active duty only changes at the period boundary to avoid a glitched pulse
        duty_act_d = (&cnt_q) ? duty_req_q : duty_act_q;
        pwm_d      = ({1'b0, cnt_q} < duty_act_q);
        nsleep_d   = (duty_req_q != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            duty_req_q <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
            nsleep_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_req_q <= duty_req_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
            nsleep_q   <= nsleep_d;
        end
    end

    assign pwm_out = pwm_q;
    assign nsleep  = nsleep_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_motor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dc_motor
//  Brief    : Randomised scoreboard bench for dc_motor against a behavioural model
//  Revision : 1.0  initial release
// ============================================================================
module tb_dc_motor;

    localparam int PWM_MAX = 256;
    localparam int STEP    = 32;
    localparam int RC      = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic pwm_out;
    logic nsleep;

    int checks = 0;
    int errors = 0;

    dc_motor dut (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .pwm_out (pwm_out),
        .nsleep  (nsleep)
    );

    always #5 clk = ~clk;

    // Behavioural model: duty and counter as plain integers
    int       m_cnt  = 0;
    int       m_act  = 0;
    int       m_req  = 0;
    int       hold_i = 0;
    int       hold_d = 0;
    bit       ih[$]  = '{1'b0, 1'b0};
    bit       dh[$]  = '{1'b0, 1'b0};
    bit       ev_i, ev_d;
    logic [1:0] e_out;
    logic [1:0] exp_q[$];

    // An event fires on the first held cycle and every RC cycles after it
    function automatic bit fires(input int h);
        return (h == 1) || (h > 1 && ((h - 1) % RC) == 0);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_act = 0; m_req = 0;
            hold_i = 0; hold_d = 0;
            ih = '{1'b0, 1'b0};
            dh = '{1'b0, 1'b0};
            exp_q.push_back(2'b00);
        end else begin
            hold_i = ih[0] ? hold_i + 1 : 0;
            hold_d = dh[0] ? hold_d + 1 : 0;
            ev_i   = fires(hold_i);
            ev_d   = fires(hold_d);
            e_out  = {(m_cnt < m_act), (m_req != 0)};
            if (m_cnt == PWM_MAX - 1) m_act = m_req;
            m_cnt = (m_cnt + 1) % PWM_MAX;
            if (ev_i && !ev_d)
                m_req = (m_req + STEP > PWM_MAX) ? PWM_MAX : m_req + STEP;
            else if (ev_d && !ev_i)
                m_req = (m_req < STEP) ? 0 : m_req - STEP;
            void'(ih.pop_front()); ih.push_back(inc);
            void'(dh.pop_front()); dh.push_back(dec);
            exp_q.push_back(e_out);
        end
    end

    // Monitor: one expected output pair per clock, compared mid-cycle
    logic [1:0] got;
    logic [1:0] want;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (!rst) want = 2'b00;
            got = {pwm_out, nsleep};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL out_cmp t=%0t {pwm_out,nsleep} got %b expected %b", $time, got, want);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_inc();
        inc = 1'b1; cyc(4);
        inc = 1'b0; cyc(4);
    endtask

    task automatic do_reset();
        rst = 1'b0; cyc(3);
        rst = 1'b1; cyc(2);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 2 * PWM_MAX) begin
            cyc(1);
            n++;
        end
        if (m_cnt != v) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt timeout: cnt %0d required %0d", m_cnt, v);
        end
    endtask

    initial begin
        // Reset held, then released with idle buttons
        cyc(10);
        rst = 1'b1;
        cyc(300);

        // Single press -> duty 32
        inc = 1'b1; cyc(5); inc = 1'b0;
        cyc(600);

        // Long hold: auto-repeat up to saturation at full duty
        inc = 1'b1; cyc(40000); inc = 1'b0;
        cyc(600);

        // From duty 64, hold dec down through zero
        do_reset();
        press_inc();
        press_inc();
        dec = 1'b1; cyc(20000); dec = 1'b0;
        cyc(600);

        // Simultaneous inc+dec at duty 96 leaves duty unchanged
        do_reset();
        press_inc(); press_inc(); press_inc();
        inc = 1'b1; dec = 1'b1; cyc(10);
        inc = 1'b0; dec = 1'b0;
        cyc(600);

        // Press mid-period; new duty applies only from the next wrap
        wait_cnt(100);
        inc = 1'b1; cyc(5); inc = 1'b0;
        cyc(300);
        wait_cnt(10);
        rst = 1'b0;
        #1;
        checks++;
        if ({pwm_out, nsleep} !== 2'b00) begin
            errors++;
            $display("FAIL async_rst {pwm_out,nsleep} got %b%b expected 00", pwm_out, nsleep);
        end
        cyc(3);
        rst = 1'b1;
        cyc(300);

        // Randomised presses and holds
        for (int k = 0; k < 20; k++) begin
            int sel, len, gap;
            sel = $urandom_range(0, 3);
            len = $urandom_range(1, 60);
            gap = $urandom_range(3, 400);
            inc = (sel == 0 || sel == 2);
            dec = (sel == 1 || sel == 2);
            if (sel == 3) begin
                inc = 1'b1;
                len = RC + $urandom_range(1, 200);
            end
            cyc(len);
            inc = 1'b0; dec = 1'b0;
            cyc(gap);
        end

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
